mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between the instruction-fetch requester (IA/IF) and
//  the data requester (MA/MO). One grant per cycle, pipelined read responses routed back by
//  owner tag, starvation guard on fetch, IF stall output.
//  Sits between pipeline stages and memory in henad.
// PARAMETERS
//  ADDR_W     24  memory address width
//  DATA_W     24  memory data width
//  MEM_LAT    1   memory read latency in cycles (1..4); mem_rdata valid MEM_LAT cycles after grant
//  STARVE_MAX 3   consecutive fetch denials before fetch gets priority (1..15)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous active-high reset
//  if_req      in   1       fetch request; held with if_addr until if_gnt
//  if_addr     in   ADDR_W  fetch address
//  if_flush    in   1       drop all outstanding fetch responses (branch/redirect)
//  if_gnt      out  1       fetch accepted this cycle
//  if_rvalid   out  1       fetch data valid
//  if_rdata    out  DATA_W  fetch data
//  if_stall    out  1       if_req & ~if_gnt
//  d_req       in   1       data request; held with d_addr/d_we/d_wdata until d_gnt
//  d_addr      in   ADDR_W  data address
//  d_we        in   1       1 = write, 0 = read
//  d_wdata     in   DATA_W  write data
//  d_gnt       out  1       data accepted this cycle
//  d_rvalid    out  1       data read valid (never for writes)
//  d_rdata     out  DATA_W  data read result
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data
// BEHAVIOUR
//  - Grant is combinational from req and registered state; at most one of if_gnt/d_gnt per cycle.
//  - mem_en = if_gnt|d_gnt; mem_addr/mem_we/mem_wdata muxed from the granted requester;
//    mem_we=0 for fetch. All zero when nothing is granted.
//  - FSM, 2 states:
//      PRI_DATA (reset state): data wins on conflict.
//      PRI_FETCH: fetch wins on conflict.
//  - starve_cnt (4 bit):
//      ++ on each cycle with if_req & ~if_gnt, saturating at STARVE_MAX.
//      Cleared on if_gnt.
//  - FSM transitions:
//      PRI_DATA -> PRI_FETCH when starve_cnt reaches STARVE_MAX.
//      PRI_FETCH -> PRI_DATA after the next if_gnt.
//  - Owner shift register, MEM_LAT deep:
//      Each entry is {valid, is_fetch}.
//      Entry 0 loads {granted & read, if_gnt} every cycle.
//      The last entry steers mem_rdata:
//        is_fetch -> if_rvalid/if_rdata;
//        else -> d_rvalid/d_rdata.
//      Both read-data outputs are driven straight from mem_rdata; rvalid is the tag.
//  - if_flush clears the valid bit of every in-flight fetch entry, and of entry 0 if
//    granted the same cycle. Data entries are unaffected.
//    if_rvalid is suppressed in the flush cycle.
//  - A fetch granted with if_flush high is still issued to memory, but its response is dropped.
//  - Writes: granted, no response entry, no rvalid.
//  - Reset (any time, async):
//      Clears FSM to PRI_DATA, starve_cnt=0 and all owner entries.
//      Outputs go to 0: gnts, rvalids, mem_en, mem_we, if_stall, and mem_addr/mem_wdata.
//      Responses in flight at reset are discarded.
//  - Back-to-back grants every cycle are allowed; throughput 1 access/cycle.
// STRUCTURE
//  - Shared package henad_pkg: owner tag typedef (valid, is_fetch) and arbiter state enum
//    ARB_PRI_DATA/ARB_PRI_FETCH.
//  - One sub-module: arb_owner_pipe (MEM_LAT-deep tag shift register with flush mask).
// TESTING
//  1. Reset mid-read: grant d read, assert rst before response.
//     -> d_rvalid never pulses; all outputs 0 during rst.
//  2. Only if_req, addr 0x000010..0x000013 on consecutive cycles.
//     -> if_gnt every cycle; if_rvalid MEM_LAT cycles later; rdata in order.
//  3. d_req and if_req held together, STARVE_MAX=3.
//     -> d_gnt 3 cycles, then if_gnt 1 cycle, then d_gnt again; if_stall high only while denied.
//  4. d write to 0x000020 with 0xABCDEF, then d read of 0x000020.
//     -> one rvalid only, for the read, d_rdata=0xABCDEF; no if_rvalid.
//  5. Fetch 0x000030 granted, if_flush the next cycle (MEM_LAT=2).
//     -> no if_rvalid; a concurrent data read still returns d_rvalid.
//  6. Simultaneous if_req+d_req in PRI_FETCH state.
//     -> if_gnt=1, d_gnt=0; state returns to PRI_DATA next cycle.

Source files
------------

// File: rtl/henad_pkg.sv
// Shared types for the memory-port arbiter.
//   owner_tag_t  : response-routing tag carried alongside an in-flight read
//   arb_state_t  : arbiter priority state
//   flush_mask() : drops the valid bit of a fetch tag while if_flush is high
package henad_pkg;

   localparam int STARVE_W = 4;

   typedef struct packed {
      logic valid;
      logic is_fetch;
   } owner_tag_t;

   typedef enum logic {
      ARB_PRI_DATA  = 1'b0,
      ARB_PRI_FETCH = 1'b1
   } arb_state_t;

   function automatic owner_tag_t flush_mask(input owner_tag_t tag, input logic flush);
      owner_tag_t res;
      res = tag;
      if (flush && tag.is_fetch) res.valid = 1'b0;
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and memory.
//   slave  : arbiter view (requests and mem_rdata in, grants/responses/memory strobes out)
//   master : requester/memory-model view (mirror of slave)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_stall;

   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_we;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_addr, d_we, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush, d_req, d_addr, d_we, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_owner_pipe.sv
// MEM_LAT-deep shift register of owner tags, one entry per issued access.
// The last entry lines up with mem_rdata and tells the top who owns it.
//   clk, rst : clock, async active-high reset (clears every entry)
//   flush    : invalidates every fetch tag in flight, including the one loading now
//   tag_in   : tag of the access granted this cycle
//   tag_out  : tag matching the current mem_rdata
module arb_owner_pipe
   import henad_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  owner_tag_t tag_in,
   output owner_tag_t tag_out
);

   owner_tag_t pipe [MEM_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= flush_mask(tag_in, flush);
         for (int i = 1; i < MEM_LAT; i++) pipe[i] <= flush_mask(pipe[i-1], flush);
      end
   end

   assign tag_out = pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// One grant per cycle, read responses routed back by owner tag, fetch
// starvation guard, fetch stall output.
//   clk, rst : clock, async active-high reset
//   bus      : mem_port_arbiter_if.slave (fetch/data request ports, memory port)
//
// state          | meaning
// ARB_PRI_DATA   | data wins a conflict (reset state)
// ARB_PRI_FETCH  | fetch starved STARVE_MAX cycles; fetch wins until its next grant
module mem_port_arbiter
   import henad_pkg::*;
#(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 24,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   arb_state_t            state;
   logic [STARVE_W-1:0]   starve_cnt;
   logic [STARVE_W-1:0]   starve_nxt;
   logic                  if_win;
   logic                  d_win;
   owner_tag_t            tag_in;
   owner_tag_t            tag_out;

   // Grants are forced low while reset is asserted so the port is quiet.
   always_comb begin
      if_win = ~rst & bus.if_req & (~bus.d_req | (state == ARB_PRI_FETCH));
      d_win  = ~rst & bus.d_req & ~if_win;
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (if_win)
         starve_nxt = '0;
      else if (bus.if_req && (starve_cnt < STARVE_LIM))
         starve_nxt = starve_cnt + 1'b1;
   end

   // Switch to fetch priority on the cycle the counter reaches the limit so
   // fetch wins the very next conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_PRI_DATA;
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         case (state)
            ARB_PRI_DATA:  if (starve_nxt == STARVE_LIM) state <= ARB_PRI_FETCH;
            ARB_PRI_FETCH: if (if_win) state <= ARB_PRI_DATA;
            default:       state <= ARB_PRI_DATA;
         endcase
      end
   end

   always_comb begin
      bus.mem_en    = if_win | d_win;
      bus.mem_we    = d_win & bus.d_we;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (if_win) begin
         bus.mem_addr = bus.if_addr;
      end else if (d_win) begin
         bus.mem_addr  = bus.d_addr;
         bus.mem_wdata = bus.d_wdata;
      end
   end

   // Writes never produce a response, so they load an invalid tag.
   always_comb begin
      tag_in.valid    = if_win | (d_win & ~bus.d_we);
      tag_in.is_fetch = if_win;
   end

   arb_owner_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_owner_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (bus.if_flush),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign bus.if_gnt    = if_win;
   assign bus.d_gnt     = d_win;
   assign bus.if_stall  = ~rst & bus.if_req & ~if_win;
   // A fetch response arriving in a flush cycle belongs to the old stream.
   assign bus.if_rvalid = tag_out.valid & tag_out.is_fetch & ~bus.if_flush;
   assign bus.d_rvalid  = tag_out.valid & ~tag_out.is_fetch;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=3.
// Memory model: 256 words, word i initialised to 0xA00000+i, read data
// returned two cycles after the access.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 24;

   typedef struct packed {
      logic        rst;
      logic        if_req;
      logic [23:0] if_addr;
      logic        if_flush;
      logic        d_req;
      logic [23:0] d_addr;
      logic        d_we;
      logic [23:0] d_wdata;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        d_gnt;
      logic        if_stall;
      logic        mem_en;
      logic        mem_we;
      logic [23:0] mem_addr;
      logic [23:0] mem_wdata;
      logic        if_rvalid;
      logic [23:0] if_rdata;
      logic        d_rvalid;
      logic [23:0] d_rdata;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   logic [23:0] mem [256];
   logic [23:0] rd0, rd1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MEM_LAT    (2),
      .STARVE_MAX (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial for (int k = 0; k < 256; k++) mem[k] = 24'hA00000 + 24'(k);

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
      rd0 <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : 24'h0;
      rd1 <= rd0;
   end
   assign bus.mem_rdata = rd1;

   function automatic in_t ii(input logic r, input logic ir, input logic [23:0] ia,
                              input logic fl, input logic dr, input logic [23:0] da,
                              input logic we, input logic [23:0] wd);
      in_t v;
      v = '{rst: r, if_req: ir, if_addr: ia, if_flush: fl, d_req: dr, d_addr: da, d_we: we, d_wdata: wd};
      return v;
   endfunction

   function automatic out_t oo(input logic ig, input logic dg, input logic st, input logic en,
                               input logic we, input logic [23:0] ma, input logic [23:0] mw,
                               input logic irv, input logic [23:0] ird,
                               input logic drv, input logic [23:0] drd);
      out_t v;
      v = '{if_gnt: ig, d_gnt: dg, if_stall: st, mem_en: en, mem_we: we, mem_addr: ma,
            mem_wdata: mw, if_rvalid: irv, if_rdata: ird, d_rvalid: drv, d_rdata: drd};
      return v;
   endfunction

   task automatic add(input in_t a, input out_t b);
      vec_t v;
      v.i = a;
      v.o = b;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t a);
      rst          = a.rst;
      bus.if_req   = a.if_req;
      bus.if_addr  = a.if_addr;
      bus.if_flush = a.if_flush;
      bus.d_req    = a.d_req;
      bus.d_addr   = a.d_addr;
      bus.d_we     = a.d_we;
      bus.d_wdata  = a.d_wdata;
   endtask

   function automatic out_t sample();
      out_t s;
      s.if_gnt    = bus.if_gnt;
      s.d_gnt     = bus.d_gnt;
      s.if_stall  = bus.if_stall;
      s.mem_en    = bus.mem_en;
      s.mem_we    = bus.mem_we;
      s.mem_addr  = bus.mem_addr;
      s.mem_wdata = bus.mem_wdata;
      s.if_rvalid = bus.if_rvalid;
      s.if_rdata  = bus.if_rvalid ? bus.if_rdata : 24'h0;
      s.d_rvalid  = bus.d_rvalid;
      s.d_rdata   = bus.d_rvalid ? bus.d_rdata : 24'h0;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic ir, input logic [23:0] ia, input logic dr, input logic [23:0] da);
      @(posedge clk);
      #1;
      drive(ii(1'b0, ir, ia, 1'b0, dr, da, 1'b0, 24'h0));
      @(negedge clk);
   endtask

   initial begin
      in_t  idle;
      out_t none;
      out_t act;
      idle = ii(0, 0, 0, 0, 0, 0, 0, 0);
      none = oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset mid-read: response to the 0x40 read must never appear
      add(ii(1, 0, 0, 0, 0, 0, 0, 0),                 none);
      add(ii(0, 0, 0, 0, 1, 24'h40, 0, 0),            oo(0, 1, 0, 1, 0, 24'h40, 0, 0, 0, 0, 0));
      add(ii(1, 1, 24'h10, 0, 1, 24'h40, 0, 0),       none);
      add(idle, none);
      add(idle, none);
      // fetch-only stream
      add(ii(0, 1, 24'h10, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h10, 0, 0, 0, 0, 0));
      add(ii(0, 1, 24'h11, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h11, 0, 0, 0, 0, 0));
      add(ii(0, 1, 24'h12, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h12, 0, 1, 24'hA00010, 0, 0));
      add(ii(0, 1, 24'h13, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h13, 0, 1, 24'hA00011, 0, 0));
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 1, 24'hA00012, 0, 0));
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 1, 24'hA00013, 0, 0));
      add(idle, none);
      // both held: data x3, fetch x1, data again
      add(ii(0, 1, 24'h50, 0, 1, 24'h60, 0, 0),       oo(0, 1, 1, 1, 0, 24'h60, 0, 0, 0, 0, 0));
      add(ii(0, 1, 24'h50, 0, 1, 24'h60, 0, 0),       oo(0, 1, 1, 1, 0, 24'h60, 0, 0, 0, 0, 0));
      add(ii(0, 1, 24'h50, 0, 1, 24'h60, 0, 0),       oo(0, 1, 1, 1, 0, 24'h60, 0, 0, 0, 1, 24'hA00060));
      add(ii(0, 1, 24'h50, 0, 1, 24'h60, 0, 0),       oo(1, 0, 0, 1, 0, 24'h50, 0, 0, 0, 1, 24'hA00060));
      add(ii(0, 1, 24'h51, 0, 1, 24'h60, 0, 0),       oo(0, 1, 1, 1, 0, 24'h60, 0, 0, 0, 1, 24'hA00060));
      add(ii(0, 1, 24'h51, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h51, 0, 1, 24'hA00050, 0, 0));
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'hA00060));
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 1, 24'hA00051, 0, 0));
      add(idle, none);
      // write then read back
      add(ii(0, 0, 0, 0, 1, 24'h20, 1, 24'hABCDEF),   oo(0, 1, 0, 1, 1, 24'h20, 24'hABCDEF, 0, 0, 0, 0));
      add(ii(0, 0, 0, 0, 1, 24'h20, 0, 0),            oo(0, 1, 0, 1, 0, 24'h20, 0, 0, 0, 0, 0));
      add(idle, none);
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'hABCDEF));
      add(idle, none);
      // fetch then flush, concurrent data read survives
      add(ii(0, 1, 24'h30, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h30, 0, 0, 0, 0, 0));
      add(ii(0, 0, 0, 1, 1, 24'h40, 0, 0),            oo(0, 1, 0, 1, 0, 24'h40, 0, 0, 0, 0, 0));
      add(idle, none);
      add(idle,                                       oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'hA00040));
      // fetch granted in a flush cycle: issued, response dropped
      add(ii(0, 1, 24'h31, 1, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h31, 0, 0, 0, 0, 0));
      add(idle, none);
      add(idle, none);
      // flush exactly in the response cycle
      add(ii(0, 1, 24'h32, 0, 0, 0, 0, 0),            oo(1, 0, 0, 1, 0, 24'h32, 0, 0, 0, 0, 0));
      add(idle, none);
      add(ii(0, 0, 0, 1, 0, 0, 0, 0),                 none);
      add(idle, none);

      drive(ii(1, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      for (int n = 0; n < vecs.size(); n++) begin
         @(posedge clk);
         #1;
         drive(vecs[n].i);
         @(negedge clk);
         act = sample();
         total++;
         if (act !== vecs[n].o) begin
            bad++;
            $display("FAIL vec%0d: got %0h expected %0h", n, act, vecs[n].o);
         end
      end

      // priority state holds through an idle cycle, then flips back after one fetch grant
      for (int k = 0; k < 3; k++) begin
         cyc(1, 24'h70, 1, 24'h71);
         chk($sformatf("pri_d_gnt%0d", k), 32'(bus.d_gnt), 32'd1);
         chk($sformatf("pri_stall%0d", k), 32'(bus.if_stall), 32'd1);
      end
      cyc(0, 0, 0, 0);
      chk("pri_idle_en", 32'(bus.mem_en), 32'd0);
      cyc(1, 24'h70, 1, 24'h71);
      chk("pri_fetch_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
      chk("pri_fetch_addr", 32'(bus.mem_addr), 32'h70);
      chk("pri_fetch_stall", 32'(bus.if_stall), 32'd0);
      cyc(1, 24'h70, 1, 24'h71);
      chk("pri_back_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
      chk("pri_back_addr", 32'(bus.mem_addr), 32'h71);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // async reset mid-cycle drops a live grant immediately
      cyc(1, 24'h12, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_gnt", {29'd0, bus.if_gnt, bus.mem_en, bus.if_stall}, 32'd0);
      chk("async_rst_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk);
      #1;
      drive(idle);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
